// File: rtl/aud_adc_deser.sv
// I2S / left-justified ADC deserializer: oversamples the codec serial port in the CLOCK domain
// and presents left/right pairs on valid/ready. Optional PEAK output: define AUD_DESER_PEAK_EN.
module aud_adc_deser #(
  parameter int SAMPLE_BITS = 16,
  parameter int I2S_DELAY   = 1
) (
  input  logic                   CLOCK,
  input  logic                   RESET,
  input  logic                   AUD_BCLK,
  input  logic                   AUD_ADCLRCK,
  input  logic                   AUD_ADCDAT,
  input  logic                   SAMPLE_READY,
  input  logic                   CLR_FLAGS,
  output logic [SAMPLE_BITS-1:0] LEFT_DATA,
  output logic [SAMPLE_BITS-1:0] RIGHT_DATA,
  output logic                   SAMPLE_VALID,
  output logic                   OVERRUN,
  output logic                   FRAME_ERR
`ifdef AUD_DESER_PEAK_EN
  ,
  output logic [SAMPLE_BITS-2:0] PEAK
`endif
);

  typedef enum logic [1:0] {WAIT_SYNC, LEFT, RIGHT} state_t;

  state_t                 r_state;
  logic [2:0]             r_bclk_s;
  logic [1:0]             r_lrck_s;
  logic [1:0]             r_dat_s;
  logic                   r_lrck_prev;
  logic [5:0]             r_cnt;
  logic [SAMPLE_BITS-1:0] r_sh;
  logic [SAMPLE_BITS-1:0] r_lhold;
  logic                   r_done;
  logic                   r_left_ok;

  logic                   w_ev, w_lr, w_dat, w_chg, w_active, w_inrng, w_cap;
  logic                   w_full, w_short, w_wdone, w_wright, w_pair;
  logic [5:0]             w_cnt;
  logic [6:0]             w_pos, w_sh_amt;
  logic [SAMPLE_BITS-1:0] w_mask, w_sh_nxt, w_word;

  // LRCK/DAT only need the stage that lines up with the BCLK edge detector.
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      r_bclk_s <= '0;
      r_lrck_s <= '0;
      r_dat_s  <= '0;
    end else begin
      r_bclk_s <= {r_bclk_s[1:0], AUD_BCLK};
      r_lrck_s <= {r_lrck_s[0], AUD_ADCLRCK};
      r_dat_s  <= {r_dat_s[0], AUD_ADCDAT};
    end
  end

  always_comb begin
    w_ev     = r_bclk_s[1] & ~r_bclk_s[2];
    w_lr     = r_lrck_s[1];
    w_dat    = r_dat_s[1];
    w_chg    = w_lr ^ r_lrck_prev;
    w_cnt    = w_chg ? '0 : r_cnt;
    w_active = (r_state != WAIT_SYNC) | (w_chg & ~w_lr);
    w_pos    = {1'b0, w_cnt} - 7'(I2S_DELAY);
    w_inrng  = ({1'b0, w_cnt} >= 7'(I2S_DELAY)) && (w_pos < 7'(SAMPLE_BITS));
    w_cap    = w_ev & w_active & w_inrng;
    w_sh_amt = 7'(SAMPLE_BITS - 1) - w_pos;
    w_mask   = {{(SAMPLE_BITS-1){1'b0}}, 1'b1} << w_sh_amt;
    // Slot register is cleared at every LRCK change, so unfilled LSBs read as zero padding.
    w_sh_nxt = w_chg ? '0 : r_sh;
    if (w_cap) w_sh_nxt = (w_sh_nxt & ~w_mask) | (w_dat ? w_mask : '0);
    w_full   = w_cap & (w_pos == 7'(SAMPLE_BITS - 1));
    w_short  = w_ev & w_chg & (r_state != WAIT_SYNC) & ~r_done;
    w_wdone  = w_short | w_full;
    w_wright = w_short ? (r_state == RIGHT) : w_lr;
    w_word   = w_short ? r_sh : w_sh_nxt;
    w_pair   = w_wdone & w_wright & r_left_ok;
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      r_state      <= WAIT_SYNC;
      r_lrck_prev  <= 1'b0;
      r_cnt        <= '0;
      r_sh         <= '0;
      r_lhold      <= '0;
      r_done       <= 1'b0;
      r_left_ok    <= 1'b0;
      LEFT_DATA    <= '0;
      RIGHT_DATA   <= '0;
      SAMPLE_VALID <= 1'b0;
      OVERRUN      <= 1'b0;
      FRAME_ERR    <= 1'b0;
    end else begin
      if (w_ev) begin
        r_lrck_prev <= w_lr;
        r_cnt       <= (w_cnt == 6'd63) ? 6'd63 : w_cnt + 6'd1;
        r_sh        <= w_sh_nxt;
        r_done      <= w_full | (r_done & ~w_chg);
        case (r_state)
          WAIT_SYNC: if (w_chg && !w_lr) r_state <= LEFT;
          default:   if (w_chg) r_state <= w_lr ? RIGHT : LEFT;
        endcase
        if (w_wdone) begin
          if (!w_wright) begin
            r_lhold   <= w_word;
            r_left_ok <= 1'b1;
          end else begin
            r_left_ok <= 1'b0;
          end
        end
      end

      if (SAMPLE_VALID && SAMPLE_READY) SAMPLE_VALID <= 1'b0;
      if (CLR_FLAGS) begin
        OVERRUN   <= 1'b0;
        FRAME_ERR <= 1'b0;
      end
      if (w_pair) begin
        LEFT_DATA    <= r_lhold;
        RIGHT_DATA   <= w_word;
        SAMPLE_VALID <= 1'b1;
        if (SAMPLE_VALID && !SAMPLE_READY) OVERRUN <= 1'b1;
      end
      if (w_short) FRAME_ERR <= 1'b1;
    end
  end

`ifdef AUD_DESER_PEAK_EN
  function automatic logic [SAMPLE_BITS-2:0] f_mag(input logic [SAMPLE_BITS-1:0] x);
    logic [SAMPLE_BITS-1:0] n;
    n = '0 - x;
    if (!x[SAMPLE_BITS-1]) return x[SAMPLE_BITS-2:0];
    if (x[SAMPLE_BITS-2:0] == '0) return '1;
    return n[SAMPLE_BITS-2:0];
  endfunction

  logic [SAMPLE_BITS-2:0] w_mag_l, w_mag_r, w_peak_nxt;

  always_comb begin
    w_mag_l    = f_mag(r_lhold);
    w_mag_r    = f_mag(w_word);
    w_peak_nxt = CLR_FLAGS ? '0 : PEAK;
    if (w_mag_l > w_peak_nxt) w_peak_nxt = w_mag_l;
    if (w_mag_r > w_peak_nxt) w_peak_nxt = w_mag_r;
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET)         PEAK <= '0;
    else if (w_pair)    PEAK <= w_peak_nxt;
    else if (CLR_FLAGS) PEAK <= '0;
  end
`endif

endmodule

// File: tb/tb_aud_adc_deser.sv
// Self-checking bench for aud_adc_deser: drives I2S frames at BCLK = CLOCK/16 and scores
// accepted pairs against a queue of expected {left,right} words.
module tb_aud_adc_deser;

  localparam int SB  = 16;
  localparam int DLY = 1;

  logic          CLOCK = 1'b0;
  logic          RESET, AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT, SAMPLE_READY, CLR_FLAGS;
  logic [SB-1:0] LEFT_DATA, RIGHT_DATA;
  logic          SAMPLE_VALID, OVERRUN, FRAME_ERR;
`ifdef AUD_DESER_PEAK_EN
  logic [SB-2:0] PEAK;
`endif

  aud_adc_deser #(.SAMPLE_BITS(SB), .I2S_DELAY(DLY)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .AUD_BCLK(AUD_BCLK), .AUD_ADCLRCK(AUD_ADCLRCK),
    .AUD_ADCDAT(AUD_ADCDAT), .SAMPLE_READY(SAMPLE_READY), .CLR_FLAGS(CLR_FLAGS),
    .LEFT_DATA(LEFT_DATA), .RIGHT_DATA(RIGHT_DATA), .SAMPLE_VALID(SAMPLE_VALID),
    .OVERRUN(OVERRUN), .FRAME_ERR(FRAME_ERR)
`ifdef AUD_DESER_PEAK_EN
    , .PEAK(PEAK)
`endif
  );

  always #10 CLOCK = ~CLOCK;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  // Scoreboard: every accepted pair must match the oldest expected pair.
  always @(negedge CLOCK) begin
    logic [31:0] e;
    if (RESET && SAMPLE_VALID && SAMPLE_READY) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pair_unexpected: got %h/%h, required no pair", LEFT_DATA, RIGHT_DATA);
      end else begin
        e = exp_q.pop_front();
        if ({LEFT_DATA, RIGHT_DATA} !== e) begin
          errors++;
          $display("FAIL pair_data: got %h/%h, required %h/%h", LEFT_DATA, RIGHT_DATA, e[31:16], e[15:0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLOCK);
    #3;
  endtask

  task automatic pulse_clr();
    tick();
    CLR_FLAGS = 1'b1;
    tick();
    CLR_FLAGS = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
  endtask

  // One BCLK period: 8 cycles low then 8 high; hist[i] = VALID at the i-th negedge after the rise.
  task automatic bclk_bit(input logic lr, input logic d, input bit pulse, output logic [7:0] hist);
    AUD_BCLK = 1'b0; AUD_ADCLRCK = lr; AUD_ADCDAT = d;
    repeat (8) tick();
    AUD_BCLK = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLOCK);
      hist[i] = SAMPLE_VALID;
      tick();
      if (pulse && i == 1) SAMPLE_READY = 1'b1;
      if (pulse && i == 2) SAMPLE_READY = 1'b0;
    end
  endtask

  // Bits first..nb-1 of a slot; mode 2 pulses READY into the load cycle of this slot's LSB.
  task automatic send_slot(input logic lr, input logic [SB-1:0] w, input int first, input int nb,
                           input int mode, output logic [7:0] hist);
    logic [7:0] h;
    int         pos;
    logic       d;
    hist = '0;
    for (int b = first; b < nb; b++) begin
      pos = b - DLY;
      d   = (pos >= 0 && pos < SB) ? w[SB-1-pos] : b[0];
      bclk_bit(lr, d, (mode == 2) && (pos == SB - 1), h);
      if (pos == SB - 1) hist = h;
    end
  endtask

  task automatic send_frame(input logic [SB-1:0] l, input logic [SB-1:0] r, input int nb,
                            input int mode, output logic [7:0] hist);
    logic [7:0] h;
    send_slot(1'b0, l, 0, nb, 0, h);
    send_slot(1'b1, r, 0, nb, mode, hist);
  endtask

  task automatic test_reset();
    logic [7:0] h;
    RESET = 1'b0; AUD_BCLK = 1'b0; AUD_ADCLRCK = 1'b0; AUD_ADCDAT = 1'b0;
    SAMPLE_READY = 1'b0; CLR_FLAGS = 1'b0;
    repeat (4) tick();
    @(negedge CLOCK);
    checks++; if (SAMPLE_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", SAMPLE_VALID); end
    checks++; if (OVERRUN !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b, required 0", OVERRUN); end
    checks++; if (FRAME_ERR !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b, required 0", FRAME_ERR); end
    checks++; if ({LEFT_DATA, RIGHT_DATA} !== 32'h0) begin errors++; $display("FAIL reset_data: got %h/%h, required 0/0", LEFT_DATA, RIGHT_DATA); end
    tick();
    RESET = 1'b1;
    SAMPLE_READY = 1'b1;
    send_slot(1'b1, 16'hFFFF, 16, 32, 0, h);
    exp_q.push_back(32'hA5A5_5A5A);
    exp_q.push_back(32'h0F0F_F0F0);
    send_frame(16'hA5A5, 16'h5A5A, 32, 0, h);
    send_frame(16'h0F0F, 16'hF0F0, 32, 0, h);
    wait_drain();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sync_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_midword();
    logic [7:0] h;
    send_slot(1'b0, 16'hFFFF, 0, 10, 0, h);
    RESET = 1'b0;
    repeat (4) tick();
    RESET = 1'b1;
    send_slot(1'b0, 16'hFFFF, 10, 32, 0, h);
    send_slot(1'b1, 16'h7777, 0, 32, 0, h);
    exp_q.push_back(32'h1357_2468);
    send_frame(16'h1357, 16'h2468, 32, 0, h);
    wait_drain();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL midword_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_normal();
    logic [7:0] h;
    SAMPLE_READY = 1'b1;
    exp_q.push_back(32'h8001_7FFE);
    send_frame(16'h8001, 16'h7FFE, 32, 1, h);
    checks++; if (h !== 8'b0000_1000) begin errors++; $display("FAIL normal_valid_timing: got %b, required 00001000", h); end
    checks++; if (LEFT_DATA !== 16'h8001) begin errors++; $display("FAIL normal_left: got %h, required 8001", LEFT_DATA); end
    checks++; if (RIGHT_DATA !== 16'h7FFE) begin errors++; $display("FAIL normal_right: got %h, required 7FFE", RIGHT_DATA); end
    checks++; if ({OVERRUN, FRAME_ERR} !== 2'b00) begin errors++; $display("FAIL normal_flags: got %b, required 00", {OVERRUN, FRAME_ERR}); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL normal_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_overrun();
    logic [7:0] h;
    SAMPLE_READY = 1'b0;
    send_frame(16'h1234, 16'h5678, 32, 0, h);
    exp_q.push_back(32'h9ABC_DEF0);
    send_frame(16'h9ABC, 16'hDEF0, 32, 0, h);
    @(negedge CLOCK);
    checks++; if ({LEFT_DATA, RIGHT_DATA} !== 32'h9ABC_DEF0) begin errors++; $display("FAIL overrun_data: got %h/%h, required 9ABC/DEF0", LEFT_DATA, RIGHT_DATA); end
    checks++; if (SAMPLE_VALID !== 1'b1) begin errors++; $display("FAIL overrun_valid: got %b, required 1", SAMPLE_VALID); end
    checks++; if (OVERRUN !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b, required 1", OVERRUN); end
    pulse_clr();
    @(negedge CLOCK);
    checks++; if (OVERRUN !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b, required 0", OVERRUN); end
    checks++; if (SAMPLE_VALID !== 1'b1) begin errors++; $display("FAIL overrun_valid_hold: got %b, required 1", SAMPLE_VALID); end
    tick();
    SAMPLE_READY = 1'b1;
    wait_drain();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL overrun_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] h;
    SAMPLE_READY = 1'b0;
    exp_q.push_back(32'h1111_EEEE);
    send_frame(16'h1111, 16'hEEEE, 32, 0, h);
    exp_q.push_back(32'hC3C3_3C3C);
    send_frame(16'hC3C3, 16'h3C3C, 32, 2, h);
    @(negedge CLOCK);
    checks++; if (h !== 8'hFF) begin errors++; $display("FAIL b2b_valid_continuous: got %b, required 11111111", h); end
    checks++; if (OVERRUN !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b, required 0", OVERRUN); end
    checks++; if ({SAMPLE_VALID, LEFT_DATA, RIGHT_DATA} !== {1'b1, 32'hC3C3_3C3C}) begin
      errors++; $display("FAIL b2b_new_pair: got %b %h/%h, required 1 C3C3/3C3C", SAMPLE_VALID, LEFT_DATA, RIGHT_DATA);
    end
    tick();
    SAMPLE_READY = 1'b1;
    wait_drain();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_short_slot();
    logic [7:0] h;
    SAMPLE_READY = 1'b1;
    exp_q.push_back(32'hABC0_5670);
    exp_q.push_back(32'h0F1E_E1F0);
    send_frame(16'hABC0, 16'h5670, 12 + DLY, 0, h);
    send_frame(16'h0F1E, 16'hE1F0, 32, 0, h);
    @(negedge CLOCK);
    checks++; if (FRAME_ERR !== 1'b1) begin errors++; $display("FAIL short_frame_err: got %b, required 1", FRAME_ERR); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL short_drain: got %0d pending, required 0", exp_q.size()); end
    pulse_clr();
    @(negedge CLOCK);
    checks++; if (FRAME_ERR !== 1'b0) begin errors++; $display("FAIL short_clear: got %b, required 0", FRAME_ERR); end
  endtask

`ifdef AUD_DESER_PEAK_EN
  task automatic test_peak();
    logic [7:0] h;
    SAMPLE_READY = 1'b1;
    pulse_clr();
    @(negedge CLOCK);
    checks++; if (PEAK !== 15'h0) begin errors++; $display("FAIL peak_clear: got %h, required 0000", PEAK); end
    exp_q.push_back(32'h0100_FF00);
    send_frame(16'h0100, 16'hFF00, 32, 0, h);
    checks++; if (PEAK !== 15'h0100) begin errors++; $display("FAIL peak_first: got %h, required 0100", PEAK); end
    exp_q.push_back(32'h8000_0001);
    send_frame(16'h8000, 16'h0001, 32, 0, h);
    checks++; if (PEAK !== 15'h7FFF) begin errors++; $display("FAIL peak_second: got %h, required 7FFF", PEAK); end
    wait_drain();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL peak_drain: got %0d pending, required 0", exp_q.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_reset_midword();
    test_normal();
    test_overrun();
    test_back_to_back();
    test_short_slot();
`ifdef AUD_DESER_PEAK_EN
    test_peak();
`endif
    repeat (4) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aud_adc_deser.md
Name: aud_adc_deser

Overview:
- Audio ADC deserializer directly downstream of the codec serial ADC port. The codec is configured over I2C for I2S slave/master operation.
- Oversamples AUD_BCLK, AUD_ADCLRCK and AUD_ADCDAT in the CLOCK domain (50 MHz) and reassembles MSB-first I2S words into parallel left/right sample pairs.
- Presents each pair on a valid/ready handshake to the downstream DSP or DAC serializer, with sticky error flags.

Parameters:
- SAMPLE_BITS, 16, bits captured per channel (MSB-first); extra slot bits are ignored. Legal range 8..32.
- I2S_DELAY, 1, BCLK rising edges after an LRCK change before the MSB (1 = I2S, 0 = left-justified).

Ports:
- CLOCK  in  1  system clock, 50 MHz
- RESET  in  1  synchronous, active-low reset
- AUD_BCLK  in  1  codec bit clock (asynchronous to CLOCK)
- AUD_ADCLRCK  in  1  codec ADC word clock: low = left, high = right
- AUD_ADCDAT  in  1  codec ADC serial data
- SAMPLE_READY  in  1  downstream accepts the pair when high at a CLOCK edge with SAMPLE_VALID high
- CLR_FLAGS  in  1  synchronous clear of OVERRUN and FRAME_ERR (and PEAK when the optional feature is enabled)
- LEFT_DATA  out  SAMPLE_BITS  left sample, two's complement
- RIGHT_DATA  out  SAMPLE_BITS  right sample, two's complement
- SAMPLE_VALID  out  1  pair available
- OVERRUN  out  1  sticky: an unaccepted pair was overwritten
- FRAME_ERR  out  1  sticky: a channel slot was shorter than SAMPLE_BITS

Behaviour:
- Clocking/reset: one clock, CLOCK. RESET is synchronous and active-low.
- Reset values: all outputs 0; state WAIT_SYNC; all shift registers and counters 0. Reset asserted mid-word discards all partial data.
- Input synchronization:
  - BCLK, LRCK and DAT each pass through a 2-flop synchronizer plus a third stage used for edge detection.
  - A "bit event" is a synced BCLK rising edge. DAT and LRCK are sampled from the same synced stage at that event.
  - BCLK high and low times must each be at least 3 CLOCK periods.
- LRCK change detection: at each bit event, LRCK is compared with its value at the previous bit event.
- States:
  - WAIT_SYNC: ignore data until an LRCK 1->0 change (start of left slot), then go to LEFT.
  - LEFT / RIGHT: at each LRCK change, reset bit counter cnt to 0 and select the channel from the new LRCK value.
- Capture rule:
  - At each bit event within a slot, position p = cnt - I2S_DELAY.
  - If 0 <= p < SAMPLE_BITS, shift DAT into the channel shift register (MSB-first); cnt saturates at 63.
  - When p = SAMPLE_BITS-1 is captured, that channel's word is complete and is copied to its hold register.
- Short slot: if LRCK changes before the word completes:
  - zero-pad the remaining LSBs;
  - treat the word as complete;
  - set FRAME_ERR.
- Pair completion: completion of the right word, provided a left word completed since the previous pair. A right word with no preceding left word is discarded and the block stays in sync.
- Output latency: LEFT_DATA, RIGHT_DATA and SAMPLE_VALID update 1 CLOCK cycle after the bit event that completes the right word.
- Handshake:
  - SAMPLE_VALID holds high with stable data until SAMPLE_VALID & SAMPLE_READY at a CLOCK edge; it then deasserts on the next cycle unless a new pair loads.
  - New pair while VALID is high and not accepted in that cycle: data is overwritten, VALID stays high, OVERRUN is set.
  - New pair in the same cycle as acceptance: the old pair is consumed, the new pair is loaded, VALID stays high, no OVERRUN.
- Flags: OVERRUN and FRAME_ERR remain set until CLR_FLAGS or RESET. If CLR_FLAGS and a set condition occur in the same cycle, set wins.
- No dependency on BCLK count per slot beyond SAMPLE_BITS + I2S_DELAY; slots up to 63 bits are supported.

Optional Feature:
- AUD_DESER_PEAK_EN defined:
  - Adds output PEAK [SAMPLE_BITS-2:0] = running maximum of |LEFT|, |RIGHT| over all pairs loaded since reset or CLR_FLAGS.
  - |most-negative| saturates to all ones.
  - PEAK updates in the same cycle the pair loads; reset value is 0.
- Not defined: the PEAK port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset and sync: after reset, hold RESET=0 for 4 cycles, then drive 2 frames starting mid right slot (BCLK = CLOCK/16, 32 BCLK per slot) -> the first partial frame is not output and the first VALID carries the first full frame.
- Normal I2S capture: SAMPLE_BITS=16, I2S_DELAY=1, L=16'h8001, R=16'h7FFE, READY=1 -> LEFT_DATA=8001, RIGHT_DATA=7FFE; VALID high 1 cycle, asserted 1 cycle after the right LSB bit event; no flags set.
- Overrun: READY=0 across two frames (L/R = 1234/5678, then 9ABC/DEF0) -> outputs 9ABC/DEF0, VALID=1, OVERRUN=1; CLR_FLAGS pulse -> OVERRUN=0.
- Simultaneous accept/load: assert READY exactly in the cycle the next pair loads -> new pair is presented, VALID stays 1, OVERRUN=0.
- Short slot: 12-bit slots carrying L=0xABC -> LEFT_DATA=16'hABC0, FRAME_ERR=1.
- Peak (AUD_DESER_PEAK_EN): pairs (0100,FF00) then (8000,0001) -> PEAK=0100 after the first pair (|FF00| = 0100), then 7FFF after the second.
